// File: rtl/game_ctrl.sv
// game_ctrl: upstream controller for the Display stage.
// Synchronises and debounces the flap button, produces a one-cycle flap pulse,
// runs the IDLE/PLAY/DEAD(/PAUSE) game-phase FSM and keeps the session best score.
// Optional feature: define PAUSE_EN to enable the PAUSE state driven by pause_sw.
// Without PAUSE_EN, pause_sw is unused and state 2'b11 is never produced.
module game_ctrl #(
    parameter int DEB_CYCLES = 500000,   // stable cycles before the debounced level moves (>=2)
    parameter int DEAD_HOLD  = 50000000  // cycles in DEAD before a restart press counts (>=1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       game_en,
    input  logic       pause_sw,
    input  logic       isDead,
    input  logic [7:0] score,
    output logic [1:0] state,
    output logic       up_button,
    output logic       flap,
    output logic [7:0] best_score
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEAD_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DEAD  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    logic              sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              up_q, up_d;
    logic              up_prev_q;
    logic              flap_q;
    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]        best_q;

`ifndef PAUSE_EN
    // pause_sw only matters when the pause feature is built in.
    logic unused_pause;
    assign unused_pause = pause_sw;
`endif

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: count consecutive cycles where the synchronised
    // level disagrees with the debounced level; any agreement restarts the count.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        up_d      = up_q;
        if (sync2_q == up_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            up_d      = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q <= '0;
            up_q      <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            up_q      <= up_d;
        end
    end

    // Registered rising-edge detect: flap is high in the cycle after up_button rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_prev_q <= 1'b0;
            flap_q    <= 1'b0;
        end else begin
            up_prev_q <= up_q;
            flap_q    <= up_q & ~up_prev_q;
        end
    end

    // Game-phase FSM with DEAD hold counter and best-score capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            best_q  <= '0;
        end else if (!game_en) begin
            // Disabling the game overrides every other transition.
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flap_q) state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    // Death wins over a simultaneous flap (flap has no PLAY transition).
                    if (isDead) begin
                        state_q <= ST_DEAD;
                        hold_q  <= '0;
                        if (score > best_q) best_q <= score;
                    end
`ifdef PAUSE_EN
                    else if (pause_sw) begin
                        state_q <= ST_PAUSE;
                    end
`endif
                end
                ST_DEAD: begin
                    // Counter saturates at DEAD_HOLD-1; only then is a restart press honoured.
                    if (hold_q == HOLD_LAST) begin
                        if (flap_q) begin
                            state_q <= ST_IDLE;
                            hold_q  <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
`ifdef PAUSE_EN
                    // flap and isDead are ignored while paused.
                    if (!pause_sw) state_q <= ST_PLAY;
`else
                    // Unreachable encoding without the pause feature: recover to IDLE.
                    state_q <= ST_IDLE;
`endif
                end
            endcase
        end
    end

    assign state      = state_q;
    assign up_button  = up_q;
    assign flap       = flap_q;
    assign best_score = best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl (DEB_CYCLES=4, DEAD_HOLD=8): directed scenarios
// followed by randomized stimulus, every cycle compared with a behavioural model.
module tb_game_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_DEAD  = 2;
    localparam int S_PAUSE = 3;
`ifdef PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       game_en;
    logic       pause_sw;
    logic       isDead;
    logic [7:0] score;
    logic [1:0] state;
    logic       up_button;
    logic       flap;
    logic [7:0] best_score;

    int tests = 0;
    int fails = 0;

    game_ctrl #(.DEB_CYCLES(DEB), .DEAD_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .game_en   (game_en),
        .pause_sw  (pause_sw),
        .isDead    (isDead),
        .score     (score),
        .state     (state),
        .up_button (up_button),
        .flap      (flap),
        .best_score(best_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // raw_q: last two raw samples (sync delay); win_q: last DEB synchronised samples.
    int raw_q[$];
    int win_q[$];
    int m_up, m_up_prev, m_flap, m_state, m_best;
    int edge_n, dead_edge;

    task automatic model_reset();
        raw_q = '{0, 0};
        win_q.delete();
        m_up = 0; m_up_prev = 0; m_flap = 0;
        m_state = S_IDLE; m_best = 0;
        edge_n = 0; dead_edge = 0;
    endtask

    task automatic model_edge();
        int s, n_up, n_flap, n_state;
        bit flip;
        if (rst) begin
            model_reset();
            return;
        end
        edge_n++;
        // Level seen by the debouncer is the raw input from two edges ago.
        s = raw_q[0];
        void'(raw_q.pop_front());
        raw_q.push_back(int'(btn_raw));
        win_q.push_back(s);
        if (win_q.size() > DEB) void'(win_q.pop_front());
        // Debounced level flips once the last DEB samples all disagree with it.
        flip = (win_q.size() == DEB);
        foreach (win_q[i]) if (win_q[i] == m_up) flip = 1'b0;
        n_up   = flip ? 1 - m_up : m_up;
        n_flap = (m_up == 1 && m_up_prev == 0) ? 1 : 0;
        // Phase rules, evaluated on the current (pre-edge) flap.
        n_state = m_state;
        if (!game_en) begin
            n_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            if (m_flap == 1) n_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (isDead) begin
                n_state   = S_DEAD;
                dead_edge = edge_n;
                if (int'(score) > m_best) m_best = int'(score);
            end else if (PAUSE_ON && pause_sw) begin
                n_state = S_PAUSE;
            end
        end else if (m_state == S_DEAD) begin
            if (m_flap == 1 && (edge_n - dead_edge) >= HOLD) n_state = S_IDLE;
        end else begin
            n_state = (PAUSE_ON && pause_sw) ? S_PAUSE : (PAUSE_ON ? S_PLAY : S_IDLE);
        end
        m_up_prev = m_up;
        m_up      = n_up;
        m_flap    = n_flap;
        m_state   = n_state;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".up"},    int'(up_button), m_up);
        chk({tag, ".flap"},  int'(flap), m_flap);
        chk({tag, ".best"},  int'(best_score), m_best);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Release for 8 cycles then hold pressed for 8: yields one flap pulse.
    task automatic press_cycle(input string tag);
        btn_raw = 1'b0;
        steps(8, tag);
        btn_raw = 1'b1;
        steps(8, tag);
    endtask

    int hold_left;
    bit flap_seen;

    initial begin
        rst = 1'b1; btn_raw = 1'b0; game_en = 1'b0; pause_sw = 1'b0;
        isDead = 1'b0; score = 8'd0;
        model_reset();
        steps(3, "reset");
        chk("reset.state", int'(state), 0);
        chk("reset.best", int'(best_score), 0);
        rst = 1'b0;
        steps(2, "post_reset");

        // Bouncing input must not move the debounced level.
        flap_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            step("bounce");
            if (flap) flap_seen = 1'b1;
        end
        chk("bounce.up", int'(up_button), 0);
        chk("bounce.noflap", int'(flap_seen), 0);
        btn_raw = 1'b1;
        steps(5, "clean_edge");
        chk("latency.up_before", int'(up_button), 0);
        step("clean_edge");
        chk("latency.up_at6", int'(up_button), 1);
        chk("latency.flap_not_yet", int'(flap), 0);
        step("clean_edge");
        chk("flap.pulse", int'(flap), 1);
        step("clean_edge");
        chk("flap.one_cycle", int'(flap), 0);

        // Start a game and die with score 17.
        btn_raw = 1'b0;
        steps(8, "release");
        game_en = 1'b1;
        btn_raw = 1'b1;
        steps(8, "start");
        chk("start.play", int'(state), S_PLAY);
        btn_raw = 1'b0;
        steps(8, "release");
        // Press shortly before dying so the flap lands early in DEAD.
        btn_raw = 1'b1;
        steps(3, "pre_die");
        score = 8'd17; isDead = 1'b1;
        step("die17");
        isDead = 1'b0;
        chk("die17.state", int'(state), S_DEAD);
        chk("die17.best", int'(best_score), 17);
        steps(3, "dead_early");
        chk("dead_early.flap", int'(flap), 1);
        step("dead_early");
        chk("dead_early.stay", int'(state), S_DEAD);
        press_cycle("restart");
        chk("restart.idle", int'(state), S_IDLE);

        // Lower score does not replace best.
        press_cycle("start2");
        chk("start2.play", int'(state), S_PLAY);
        score = 8'd5; isDead = 1'b1;
        step("die5");
        isDead = 1'b0;
        chk("die5.state", int'(state), S_DEAD);
        chk("die5.best", int'(best_score), 17);

        // game_en low forces IDLE from DEAD.
        game_en = 1'b0;
        step("disable");
        chk("disable.idle", int'(state), S_IDLE);
        game_en = 1'b1;

        // isDead and flap in the same PLAY cycle: death wins.
        press_cycle("start3");
        chk("start3.play", int'(state), S_PLAY);
        btn_raw = 1'b0;
        steps(8, "release");
        btn_raw = 1'b1;
        steps(7, "flap_die");
        chk("flap_die.flap", int'(flap), 1);
        isDead = 1'b1;
        step("flap_die");
        isDead = 1'b0;
        chk("flap_die.dead", int'(state), S_DEAD);

        // Reset in the middle of a game.
        press_cycle("to_idle");
        press_cycle("start4");
        chk("start4.play", int'(state), S_PLAY);
        #2;
        rst = 1'b1;
        btn_raw = 1'b0;
        #1;
        model_reset();
        chk("midrst.state", int'(state), 0);
        chk("midrst.best", int'(best_score), 0);
        chk("midrst.up", int'(up_button), 0);
        steps(2, "midrst");
        rst = 1'b0;
        steps(10, "after_rst");
        chk("after_rst.state", int'(state), 0);
        chk("after_rst.best", int'(best_score), 0);

`ifdef PAUSE_EN
        press_cycle("start5");
        btn_raw = 1'b0;
        chk("start5.play", int'(state), S_PLAY);
        pause_sw = 1'b1;
        step("pause");
        chk("pause.state", int'(state), S_PAUSE);
        isDead = 1'b1;
        steps(2, "pause_dead");
        isDead = 1'b0;
        chk("pause_dead.state", int'(state), S_PAUSE);
        pause_sw = 1'b0;
        step("unpause");
        chk("unpause.state", int'(state), S_PLAY);
`endif

        // Randomized stimulus against the model.
        hold_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_left == 0) begin
                btn_raw   = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 10);
            end
            hold_left--;
            isDead  = ($urandom_range(0, 9) == 0);
            score   = 8'($urandom);
            game_en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 5) == 0) pause_sw = ~pause_sw;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
